// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus multiplexer: FSM state encoding,
// default geometry/region map, and the timeout counter width helper.
package mem_bus_pkg;

  localparam int         DEF_NUM_SLV = 2;
  localparam int         DEF_ADDR_W  = 32;
  localparam int         DEF_DATA_W  = 32;
  localparam int         DEF_SEL_W   = 4;
  localparam logic [7:0] DEF_SLV_MAP = {4'h4, 4'h2};
  localparam int         DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Wide enough to hold TIMEOUT; keeps one bit when the timeout is disabled.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_decoder.sv
// Region decoder: matches the address region field against the slave map
// and returns a one-hot hit vector plus the binary index of the winner.
module mem_bus_decoder
  import mem_bus_pkg::*;
#(
  parameter int                         NUM_SLV = DEF_NUM_SLV,
  parameter int                         SEL_W   = DEF_SEL_W,
  parameter logic [NUM_SLV*SEL_W-1:0]   SLV_MAP = DEF_SLV_MAP,
  parameter int                         IDX_W   = $clog2(NUM_SLV)
) (
  input  logic [SEL_W-1:0]   region,
  output logic [NUM_SLV-1:0] hit,
  output logic [IDX_W-1:0]   idx,
  output logic               match
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    hit   = '0;
    idx   = '0;
    match = 1'b0;
    // Scanning downwards lets the lowest matching index overwrite the rest.
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (SLV_MAP[i*SEL_W +: SEL_W] == region) begin
        hit    = '0;
        hit[i] = 1'b1;
        idx    = IDX_W'(i);
        match  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bus_mux.sv
// Single-master to NUM_SLV-slave bus multiplexer with region decode,
// per-transaction acknowledge timeout and a saturating error counter.
module mem_bus_mux
  import mem_bus_pkg::*;
#(
  parameter int                         NUM_SLV = DEF_NUM_SLV,
  parameter int                         ADDR_W  = DEF_ADDR_W,
  parameter int                         DATA_W  = DEF_DATA_W,
  parameter int                         SEL_W   = DEF_SEL_W,
  parameter logic [NUM_SLV*SEL_W-1:0]   SLV_MAP = DEF_SLV_MAP,
  parameter int                         TIMEOUT = DEF_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        m_req,
  input  logic [ADDR_W-1:0]           m_addr,
  input  logic                        m_we,
  input  logic [DATA_W-1:0]           m_wdata,
  input  logic [DATA_W/8-1:0]         m_wstrb,
  output logic                        m_ack,
  output logic                        m_err,
  output logic [DATA_W-1:0]           m_rdata,
  output logic [NUM_SLV-1:0]          s_req,
  output logic [ADDR_W-1:0]           s_addr,
  output logic                        s_we,
  output logic [DATA_W-1:0]           s_wdata,
  output logic [DATA_W/8-1:0]         s_wstrb,
  input  logic [NUM_SLV-1:0]          s_ack,
  input  logic [NUM_SLV*DATA_W-1:0]   s_rdata,
  output logic [7:0]                  err_cnt
);

  localparam int IDX_W  = $clog2(NUM_SLV);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t              state, state_nxt;
  logic [NUM_SLV-1:0]  dec_hit, hit_q;
  logic [IDX_W-1:0]    dec_idx, idx_q;
  logic                dec_match;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [CNT_W-1:0]    cnt;
  logic                sel_ack, timed_out, err_evt;
  logic [DATA_W-1:0]   slv_rdata [NUM_SLV];

  mem_bus_decoder #(
    .NUM_SLV (NUM_SLV),
    .SEL_W   (SEL_W),
    .SLV_MAP (SLV_MAP),
    .IDX_W   (IDX_W)
  ) u_decoder (
    .region (m_addr[ADDR_W-1 -: SEL_W]),
    .hit    (dec_hit),
    .idx    (dec_idx),
    .match  (dec_match)
  );

  for (genvar g = 0; g < NUM_SLV; g++) begin : g_unpack
    assign slv_rdata[g] = s_rdata[g*DATA_W +: DATA_W];
  end

  // Masking with the latched one-hot vector discards acks from other ports.
  assign sel_ack   = |(s_ack & hit_q);
  assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);
  assign err_evt   = ((state == ST_IDLE) && m_req && !dec_match) ||
                     ((state == ST_WAIT) && !sel_ack && timed_out);

  assign s_addr  = addr_q;
  assign s_we    = we_q;
  assign s_wdata = wdata_q;
  assign s_wstrb = wstrb_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_req     = '0;
    m_ack     = 1'b0;
    m_err     = 1'b0;
    m_rdata   = '0;
    case (state)
      ST_IDLE: begin
        if (m_req) state_nxt = dec_match ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        s_req = hit_q;
        if (sel_ack || timed_out) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        m_ack     = 1'b1;
        m_err     = err_q;
        m_rdata   = rdata_q;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      hit_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m_req) begin
            addr_q  <= m_addr;
            we_q    <= m_we;
            wdata_q <= m_wdata;
            wstrb_q <= m_wstrb;
            hit_q   <= dec_hit;
            idx_q   <= dec_idx;
            err_q   <= !dec_match;
            rdata_q <= '0;
            cnt     <= '0;
          end
        end
        ST_WAIT: begin
          // A same-cycle ack beats the timeout; rdata_q stays 0 on error.
          if (sel_ack)        rdata_q <= we_q ? '0 : slv_rdata[idx_q];
          else if (timed_out) err_q   <= 1'b1;
          else                cnt     <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                            err_cnt <= '0;
    else if (err_evt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end

endmodule

// File: tb/tb_mem_bus_mux.sv
// Directed bench for mem_bus_mux: decode hit/miss, slave latency, timeout,
// reset in WAIT, spurious acks and error counter saturation.
module tb_mem_bus_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_req;
  logic [31:0] m_addr;
  logic        m_we;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ack;
  logic        m_err;
  logic [31:0] m_rdata;
  logic [1:0]  s_req;
  logic [31:0] s_addr;
  logic        s_we;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_ack;
  logic [63:0] s_rdata;
  logic [7:0]  err_cnt;

  int n_vec = 0;
  int n_bad = 0;

  mem_bus_mux #(.TIMEOUT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .m_req   (m_req),
    .m_addr  (m_addr),
    .m_we    (m_we),
    .m_wdata (m_wdata),
    .m_wstrb (m_wstrb),
    .m_ack   (m_ack),
    .m_err   (m_err),
    .m_rdata (m_rdata),
    .s_req   (s_req),
    .s_addr  (s_addr),
    .s_we    (s_we),
    .s_wdata (s_wdata),
    .s_wstrb (s_wstrb),
    .s_ack   (s_ack),
    .s_rdata (s_rdata),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                       input logic [3:0] wstrb);
    m_req   = 1'b1;
    m_addr  = addr;
    m_we    = we;
    m_wdata = wdata;
    m_wstrb = wstrb;
  endtask

  initial begin
    rst = 1'b1; m_req = 1'b0; m_addr = '0; m_we = 1'b0; m_wdata = '0; m_wstrb = '0;
    s_ack = '0; s_rdata = '0;
    tick(); tick();
    check("rst_m_ack", m_ack, 0);
    check("rst_s_req", s_req, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_s_addr", s_addr, 0);
    check("rst_m_rdata", m_rdata, 0);
    rst = 1'b0;
    tick();

    // Read hit on slave 0 with a same-cycle ack.
    start(32'h2000_0010, 1'b0, '0, '0);
    tick();
    check("rd_s_req", s_req, 2'b01);
    check("rd_s_addr", s_addr, 32'h2000_0010);
    check("rd_no_ack_c1", m_ack, 0);
    s_ack = 2'b01; s_rdata = {32'h1111_1111, 32'hDEAD_BEEF};
    tick();
    check("rd_m_ack", m_ack, 1);
    check("rd_m_rdata", m_rdata, 32'hDEAD_BEEF);
    check("rd_m_err", m_err, 0);
    check("rd_s_req_drop", s_req, 0);
    m_req = 1'b0; s_ack = '0;
    tick();
    check("rd_ack_one_cycle", m_ack, 0);

    // Write to slave 1, ack in the fourth WAIT cycle (also the timeout boundary).
    start(32'h4000_0000, 1'b1, 32'hCAFE_F00D, 4'b0101);
    tick();
    check("wr_s_we", s_we, 1);
    check("wr_s_wdata", s_wdata, 32'hCAFE_F00D);
    check("wr_s_wstrb", s_wstrb, 4'b0101);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wr_s_req_c%0d", i + 1), s_req, 2'b10);
      check($sformatf("wr_no_ack_c%0d", i + 1), m_ack, 0);
      if (i == 3) begin
        s_ack = 2'b10; s_rdata = {32'h5555_5555, 32'h0};
      end
      tick();
    end
    check("wr_m_ack", m_ack, 1);
    check("wr_m_rdata", m_rdata, 0);
    check("wr_m_err", m_err, 0);
    check("wr_s_req_drop", s_req, 0);
    m_req = 1'b0; s_ack = '0;
    tick();

    // Unmapped region: error response in cycle 1, no slave request.
    start(32'h8000_0000, 1'b0, '0, '0);
    tick();
    check("um_m_ack", m_ack, 1);
    check("um_m_err", m_err, 1);
    check("um_s_req", s_req, 0);
    check("um_err_cnt", err_cnt, 1);
    check("um_m_rdata", m_rdata, 0);
    m_req = 1'b0;
    tick();
    check("um_ack_one_cycle", m_ack, 0);

    // No ack: four WAIT cycles, then an error response.
    start(32'h2000_0000, 1'b0, '0, '0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_s_req_c%0d", i + 1), s_req, 2'b01);
      check($sformatf("to_no_ack_c%0d", i + 1), m_ack, 0);
      tick();
    end
    check("to_s_req_drop", s_req, 0);
    check("to_m_ack", m_ack, 1);
    check("to_m_err", m_err, 1);
    check("to_err_cnt", err_cnt, 2);
    m_req = 1'b0;
    tick();

    // Reset in the middle of WAIT.
    start(32'h4000_0004, 1'b0, '0, '0);
    tick();
    check("rw_s_req", s_req, 2'b10);
    tick();
    rst = 1'b1; m_req = 1'b0;
    tick();
    check("rw_s_req_drop", s_req, 0);
    check("rw_no_ack", m_ack, 0);
    check("rw_err_cnt", err_cnt, 0);
    rst = 1'b0;
    tick();
    check("rw_no_ack_after", m_ack, 0);

    // Spurious ack on the unselected port is ignored.
    start(32'h4000_0008, 1'b0, '0, '0);
    tick();
    s_ack = 2'b01; s_rdata = {32'h0, 32'hBAD0_BAD0};
    tick();
    check("sp_no_ack", m_ack, 0);
    check("sp_s_req", s_req, 2'b10);
    s_ack = 2'b10; s_rdata = {32'h1234_5678, 32'hBAD0_BAD0};
    tick();
    check("sp_m_ack", m_ack, 1);
    check("sp_m_rdata", m_rdata, 32'h1234_5678);
    check("sp_m_err", m_err, 0);
    m_req = 1'b0; s_ack = '0;
    tick();

    // Error counter saturation.
    check("sat_start", err_cnt, 0);
    for (int i = 0; i < 256; i++) begin
      start(32'hF000_0000, 1'b0, '0, '0);
      tick();
      if (i == 254) check("sat_reach_255", err_cnt, 255);
      m_req = 1'b0;
      tick();
    end
    check("sat_hold_255", err_cnt, 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_mux.md
MEM_BUS_MUX -- requirements
Module: mem_bus_mux

Interface
REQ-001 SHALL have parameter NUM_SLV, default 2: number of slave ports, range 2..8.
REQ-002 SHALL have parameter ADDR_W, default 32: address width.
REQ-003 SHALL have parameter DATA_W, default 32: data width, a multiple of 8.
REQ-004 SHALL have parameter SEL_W, default 4: width of the region field, taken from m_addr[ADDR_W-1 -: SEL_W].
REQ-005 SHALL have parameter SLV_MAP, default {4'h4, 4'h2}: region id of slave i at bits [i*SEL_W +: SEL_W].
REQ-006 SHALL have parameter TIMEOUT, default 255: maximum wait cycles for a slave acknowledge; 0 disables the timeout.
REQ-007 SHALL use one clock and a synchronous, active-high reset.
REQ-008 Port: clk  in  1  clock; all logic uses the rising edge.
REQ-009 Port: rst  in  1  synchronous active-high reset.
REQ-010 Port: m_req  in  1  master request; held with its fields until m_ack.
REQ-011 Port: m_addr  in  ADDR_W  master address.
REQ-012 Port: m_we  in  1  write enable; 0 means read.
REQ-013 Port: m_wdata  in  DATA_W  write data.
REQ-014 Port: m_wstrb  in  DATA_W/8  byte strobes.
REQ-015 Port: m_ack  out  1  one-cycle completion pulse.
REQ-016 Port: m_err  out  1  error flag, qualified by m_ack.
REQ-017 Port: m_rdata  out  DATA_W  read data, qualified by m_ack.
REQ-018 Port: s_req  out  NUM_SLV  one-hot slave request.
REQ-019 Port: s_addr, s_we, s_wdata, s_wstrb  out  (widths as the m_ fields)  latched request fields, shared by all slaves.
REQ-020 Port: s_ack  in  NUM_SLV  per-slave acknowledge.
REQ-021 Port: s_rdata  in  NUM_SLV*DATA_W  per-slave read data; slave i at [i*DATA_W +: DATA_W].
REQ-022 Port: err_cnt  out  8  saturating count of error responses.

Function
REQ-023 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-024 Decode SHALL compare the region field against SLV_MAP; on duplicate ids the lowest index wins.
REQ-025 IDLE with m_req=1 SHALL latch the address, we, wdata, wstrb and slave index at the clock edge.
REQ-026 On a decode hit, IDLE SHALL go to WAIT; on a miss it SHALL go to RESP with the error flag set.
REQ-027 In WAIT, s_req[idx] SHALL be 1 and all s_ outputs SHALL be stable; every other s_req bit SHALL be 0.
REQ-028 WAIT with s_ack[idx]=1 SHALL capture the read data (0 for writes), drop s_req and go to RESP.
REQ-029 WAIT SHALL count cycles; when the count reaches TIMEOUT without an ack, it SHALL drop s_req and go to RESP with the error flag set.
REQ-030 RESP SHALL assert m_ack for exactly one cycle, drive m_rdata (0 on error) and m_err, then return to IDLE.
REQ-031 Minimum latency: m_req sampled at edge 0, s_req high in cycle 1, a same-cycle s_ack, m_ack in cycle 2; an unmapped access acks in cycle 1.
REQ-032 s_ack on an unselected port, or while s_req is low, SHALL be ignored.
REQ-033 m_req SHALL be ignored outside IDLE.
REQ-034 err_cnt SHALL increment once per error response and saturate at 255.
REQ-035 The timeout counter SHALL be clog2(TIMEOUT+1) bits wide and SHALL clear on every entry to WAIT.

Reset
REQ-036 rst SHALL force state IDLE.
REQ-037 rst SHALL force all outputs, counters and latches to 0.
REQ-038 rst asserted during WAIT SHALL drop s_req at the next edge and SHALL NOT produce m_ack.

Structure
REQ-039 Package mem_bus_pkg SHALL hold the state encoding and the default widths and ids.
REQ-040 A combinational sub-module mem_bus_decoder SHALL produce the one-hot hit vector and the index.

Verification
REQ-041 Read to 0x2000_0010, slave 0 acks in the same cycle with 0xDEADBEEF -> m_ack in cycle 2, m_rdata=0xDEADBEEF, m_err=0.
REQ-042 Write to 0x4000_0000, slave 1 acks after 3 cycles -> s_req[1] high for 4 cycles, s_req[0] never high, m_ack with m_rdata=0.
REQ-043 Access to 0x8000_0000 -> m_ack in cycle 1, m_err=1, no s_req, err_cnt=1.
REQ-044 TIMEOUT=4 and no ack -> s_req drops after 4 cycles, then m_ack with m_err=1.
REQ-045 rst during WAIT -> s_req=0 at the next edge, no m_ack, err_cnt=0.
REQ-046 Spurious s_ack[0] while slave 1 is selected -> ignored, and the transaction completes on s_ack[1].
